// File: rtl/cursor_tx_scheduler_if.sv
// Signal bundle between the decoder pipeline, the scheduler and the 6-byte
// cursor UART transmitter.
// Handshake: in_valid is a one-clock sample strobe with no backpressure, and
// every strobed sample is consumed. tx_send is a one-clock launch that the
// transmitter accepts by raising tx_busy. tx_send is only issued while
// tx_busy is low.
interface cursor_tx_scheduler_if;
   logic              enable;
   logic              in_valid;
   logic signed [7:0] in_dx;
   logic signed [7:0] in_dy;
   logic [1:0]        in_buttons;
   logic [3:0]        in_safety;
   logic              tx_busy;
   logic              tx_send;
   logic signed [7:0] tx_dx;
   logic signed [7:0] tx_dy;
   logic [1:0]        tx_buttons;
   logic [3:0]        tx_safety;
   logic [7:0]        tx_frame_id;
   logic              acc_sat;
   logic              tx_fault;

   modport master (
      input  enable, in_valid, in_dx, in_dy, in_buttons, in_safety, tx_busy,
      output tx_send, tx_dx, tx_dy, tx_buttons, tx_safety, tx_frame_id,
             acc_sat, tx_fault
   );

   modport slave (
      output enable, in_valid, in_dx, in_dy, in_buttons, in_safety, tx_busy,
      input  tx_send, tx_dx, tx_dy, tx_buttons, tx_safety, tx_frame_id,
             acc_sat, tx_fault
   );
endinterface

// File: rtl/cursor_tx_scheduler.sv
// Frame scheduler for the cursor UART transmitter. It accumulates motion,
// decides when a frame is due, launches it, enforces the inter-frame gap
// and flags a transmitter that never accepts a launch.
module cursor_tx_scheduler #(
   parameter int MIN_GAP_CLKS   = 1000,
   parameter int HEARTBEAT_CLKS = 5000000,
   parameter int ACC_W          = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   cursor_tx_scheduler_if.master bus,
   output logic [2:0]            dbg_state_o
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   // Two guard bits so acc - emitted + delta never wraps before clipping.
   localparam int SW    = ACC_W + 2;
   localparam int HB_W  = $clog2(HEARTBEAT_CLKS + 1);
   localparam int GAP_W = $clog2(MIN_GAP_CLKS + 1);

   localparam logic signed [SW-1:0]    ACC_MAX  = SW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SW-1:0]    ACC_MIN  = -ACC_MAX;
   localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] CLAMP_LO = -CLAMP_HI;
   localparam logic [HB_W-1:0]         HB_LIM   = HB_W'(HEARTBEAT_CLKS - 1);
   localparam logic [GAP_W-1:0]        GAP_LAST = GAP_W'(MIN_GAP_CLKS - 1);

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
   logic signed [7:0]       tx_dx_q, tx_dy_q, emit_x, emit_y;
   logic [1:0]              tx_buttons_q;
   logic [3:0]              tx_safety_q;
   logic [7:0]              tx_frame_id_q, fid_cnt_q;
   logic [HB_W-1:0]         hb_q;
   logic [1:0]              wb_cnt_q;
   logic [GAP_W-1:0]        gap_cnt_q;
   logic                    acc_sat_q, tx_fault_q;
   logic                    trigger, launch, clip_any, wb_timeout;
   logic signed [SW-1:0]    sum_x, sum_y;
   logic [ACC_W:0]          sat_x, sat_y;

   // Clip to the symmetric accumulator range; the MSB of the result flags a clip.
   function automatic logic [ACC_W:0] sat_acc(input logic signed [SW-1:0] v);
      if (v > ACC_MAX)      sat_acc = {1'b1, ACC_MAX[ACC_W-1:0]};
      else if (v < ACC_MIN) sat_acc = {1'b1, ACC_MIN[ACC_W-1:0]};
      else                  sat_acc = {1'b0, v[ACC_W-1:0]};
   endfunction

   // Frame delta: -128 is never emitted, so the range is symmetric.
   function automatic logic signed [7:0] clamp8(input logic signed [ACC_W-1:0] a);
      if (a > CLAMP_HI)      clamp8 = 8'sd127;
      else if (a < CLAMP_LO) clamp8 = -8'sd127;
      else                   clamp8 = a[7:0];
   endfunction

   // Frame-due decision and next accumulator value, including launch residue.
   always_comb begin
      emit_x  = clamp8(acc_x_q);
      emit_y  = clamp8(acc_y_q);
      trigger = bus.enable && !bus.tx_busy &&
                ((acc_x_q != '0) || (acc_y_q != '0) ||
                 (bus.in_buttons != tx_buttons_q) ||
                 (bus.in_safety != tx_safety_q) || (hb_q >= HB_LIM));
      launch  = (state_q == IDLE) && trigger;
      sum_x   = SW'(acc_x_q);
      sum_y   = SW'(acc_y_q);
      if (launch) begin
         sum_x = sum_x - SW'(emit_x);
         sum_y = sum_y - SW'(emit_y);
      end
      if (bus.in_valid) begin
         sum_x = sum_x + SW'($signed(bus.in_dx));
         sum_y = sum_y + SW'($signed(bus.in_dy));
      end
      sat_x    = sat_acc(sum_x);
      sat_y    = sat_acc(sum_y);
      acc_x_d  = sat_x[ACC_W-1:0];
      acc_y_d  = sat_y[ACC_W-1:0];
      clip_any = sat_x[ACC_W] | sat_y[ACC_W];
      if (!bus.enable) begin
         acc_x_d  = '0;
         acc_y_d  = '0;
         clip_any = 1'b0;
      end
   end

   // Next-state logic; an in-flight frame always runs to completion.
   always_comb begin
      state_d    = state_q;
      wb_timeout = (state_q == WAIT_BUSY) && !bus.tx_busy && (wb_cnt_q == 2'd3);
      case (state_q)
         IDLE:      if (launch) state_d = LAUNCH;
         LAUNCH:    state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy)     state_d = WAIT_DONE;
            else if (wb_timeout) state_d = GAP;
         end
         WAIT_DONE: if (!bus.tx_busy) state_d = GAP;
         GAP:       if (gap_cnt_q == GAP_LAST) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Accumulators, frame fields, timers and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_x_q       <= '0;
         acc_y_q       <= '0;
         tx_dx_q       <= '0;
         tx_dy_q       <= '0;
         tx_buttons_q  <= '0;
         tx_safety_q   <= '0;
         tx_frame_id_q <= '0;
         fid_cnt_q     <= '0;
         hb_q          <= '0;
         wb_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         acc_sat_q     <= 1'b0;
         tx_fault_q    <= 1'b0;
      end else begin
         acc_x_q <= acc_x_d;
         acc_y_q <= acc_y_d;
         if (clip_any) acc_sat_q <= 1'b1;
         if (launch) begin
            tx_dx_q       <= emit_x;
            tx_dy_q       <= emit_y;
            tx_buttons_q  <= bus.in_buttons;
            tx_safety_q   <= bus.in_safety;
            tx_frame_id_q <= fid_cnt_q;
            fid_cnt_q     <= fid_cnt_q + 8'd1;
         end
         if (state_q == LAUNCH) hb_q <= '0;
         else if (hb_q != '1)   hb_q <= hb_q + 1'b1;
         wb_cnt_q  <= (state_q == WAIT_BUSY) ? wb_cnt_q + 2'd1 : 2'd0;
         gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
         if (wb_timeout) tx_fault_q <= 1'b1;
      end
   end

   assign bus.tx_send     = (state_q == LAUNCH);
   assign bus.tx_dx       = tx_dx_q;
   assign bus.tx_dy       = tx_dy_q;
   assign bus.tx_buttons  = tx_buttons_q;
   assign bus.tx_safety   = tx_safety_q;
   assign bus.tx_frame_id = tx_frame_id_q;
   assign bus.acc_sat     = acc_sat_q;
   assign bus.tx_fault    = tx_fault_q;
   assign dbg_state_o     = state_q;
endmodule
